// File: rtl/move_list_store_pkg.sv
// Shared definitions for the move-list store: state encodings, UCI field
// offsets and per-move flag bit positions.
package move_list_store_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd1;
  localparam logic [1:0] StReady = 2'd2;
  localparam logic [1:0] StClear = 2'd3;

  // UCI move layout: {promotion[15:12], to[11:6], from[5:0]}
  localparam int unsigned UciPromoLsb = 12;
  localparam int unsigned UciToLsb    = 6;
  localparam int unsigned UciFromLsb  = 0;

  // Flag layout: {capture, white_in_check, black_in_check, thrice_rep, fifty_move}
  localparam int unsigned FlagCapture    = 4;
  localparam int unsigned FlagWhiteCheck = 3;
  localparam int unsigned FlagBlackCheck = 2;
  localparam int unsigned FlagThriceRep  = 1;
  localparam int unsigned FlagFiftyMove  = 0;

endpackage

// File: rtl/move_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-old-data),
// no reset so it maps onto block RAM.
module move_ram #(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 45
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [DataWidth-1:0] wr_data,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [DataWidth-1:0] rd_data
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/move_list_store.sv
// Write side of the move list: buffers generated moves, serves indexed
// registered reads, and hands the list to a consumer until it is cleared.
module move_list_store
  import move_list_store_pkg::*;
#(
  parameter int unsigned MAX_POSITIONS_LOG2 = 8,
  parameter int unsigned UCI_WIDTH          = 16,
  parameter int unsigned EVAL_WIDTH         = 24,
  parameter int unsigned FLAG_WIDTH         = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          gen_start,
  input  logic                          gen_wr_en,
  input  logic [UCI_WIDTH-1:0]          gen_uci,
  input  logic signed [EVAL_WIDTH-1:0]  gen_eval,
  input  logic [FLAG_WIDTH-1:0]         gen_flags,
  input  logic                          gen_done,
  output logic                          gen_busy,
  output logic                          am_idle,
  output logic                          am_moves_ready,
  output logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
  output logic                          am_overflow,
  input  logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
  output logic [UCI_WIDTH-1:0]          uci_out,
  output logic signed [EVAL_WIDTH-1:0]  eval_out,
  output logic [FLAG_WIDTH-1:0]         flags_out,
  input  logic                          am_clear_moves
);

  localparam int unsigned DataWidth = UCI_WIDTH + EVAL_WIDTH + FLAG_WIDTH;
  localparam logic [MAX_POSITIONS_LOG2-1:0] CountMax = '1;

  logic [1:0]                    state_q, state_d;
  logic [MAX_POSITIONS_LOG2-1:0] count_q, count_d;
  logic                          ovf_q, ovf_d;
  logic                          rd_valid_q;
  logic                          ram_wr_en;
  logic [DataWidth-1:0]          ram_rd_data;

  // Capacity is one less than the RAM depth so the count never wraps.
  assign ram_wr_en = (state_q == StFill) && gen_wr_en && (count_q != CountMax);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (gen_start) begin
          state_d = StFill;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      StFill: begin
        if (gen_wr_en) begin
          if (count_q != CountMax) begin
            count_d = count_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (am_clear_moves) begin
          state_d = StClear;
        end else if (gen_done) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (am_clear_moves) begin
          state_d = StClear;
        end
      end
      StClear: begin
        count_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= (am_move_index < count_q);
    end
  end

  move_ram #(
    .AddrWidth (MAX_POSITIONS_LOG2),
    .DataWidth (DataWidth)
  ) u_move_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (count_q),
    .wr_data ({gen_uci, gen_eval, gen_flags}),
    .rd_addr (am_move_index),
    .rd_data (ram_rd_data)
  );

  assign {uci_out, eval_out, flags_out} = rd_valid_q ? ram_rd_data : '0;

  assign gen_busy       = (state_q == StFill);
  assign am_idle        = (state_q == StIdle);
  assign am_moves_ready = (state_q == StReady);
  assign am_move_count  = count_q;
  assign am_overflow    = ovf_q;

endmodule

// File: tb/tb_move_list_store.sv
// Scoreboard bench for move_list_store: stimulus pushes expected reads/status,
// a negedge monitor pops and compares.
module tb_move_list_store;

  localparam int unsigned W = 3;

  typedef struct packed {
    logic [15:0]        uci;
    logic signed [23:0] eval;
    logic [4:0]         flags;
  } entry_t;

  typedef struct packed {
    logic         idle;
    logic         busy;
    logic         ready;
    logic         ovf;
    logic         chk_cnt;
    logic [W-1:0] cnt;
    logic         chk_out;
  } status_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               gen_start = 1'b0;
  logic               gen_wr_en = 1'b0;
  logic [15:0]        gen_uci = '0;
  logic signed [23:0] gen_eval = '0;
  logic [4:0]         gen_flags = '0;
  logic               gen_done = 1'b0;
  logic               gen_busy;
  logic               am_idle;
  logic               am_moves_ready;
  logic [W-1:0]       am_move_count;
  logic               am_overflow;
  logic [W-1:0]       am_move_index = '0;
  logic [15:0]        uci_out;
  logic signed [23:0] eval_out;
  logic [4:0]         flags_out;
  logic               am_clear_moves = 1'b0;

  int checks = 0;
  int errors = 0;

  entry_t  rd_q[$];
  status_t st_q[$];
  logic    rd_issue = 1'b0;
  logic    rd_seen = 1'b0;
  logic    finishing = 1'b0;
  logic    reported = 1'b0;

  move_list_store #(
    .MAX_POSITIONS_LOG2 (W),
    .UCI_WIDTH          (16),
    .EVAL_WIDTH         (24),
    .FLAG_WIDTH         (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .gen_start      (gen_start),
    .gen_wr_en      (gen_wr_en),
    .gen_uci        (gen_uci),
    .gen_eval       (gen_eval),
    .gen_flags      (gen_flags),
    .gen_done       (gen_done),
    .gen_busy       (gen_busy),
    .am_idle        (am_idle),
    .am_moves_ready (am_moves_ready),
    .am_move_count  (am_move_count),
    .am_overflow    (am_overflow),
    .am_move_index  (am_move_index),
    .uci_out        (uci_out),
    .eval_out       (eval_out),
    .flags_out      (flags_out),
    .am_clear_moves (am_clear_moves)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_seen <= rd_issue;

  // Monitor: read results one cycle after issue, status on the next negedge.
  always @(negedge clk) begin
    entry_t  e;
    status_t s;
    if (rd_seen) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_underflow: read returned with no expectation queued");
      end else begin
        e = rd_q.pop_front();
        if (uci_out !== e.uci || eval_out !== e.eval || flags_out !== e.flags) begin
          errors++;
          $display("FAIL read: got uci=%h eval=%0d flags=%b, want uci=%h eval=%0d flags=%b",
                   uci_out, eval_out, flags_out, e.uci, e.eval, e.flags);
        end
      end
    end
    if (st_q.size() != 0) begin
      s = st_q.pop_front();
      checks++;
      if (am_idle !== s.idle || gen_busy !== s.busy || am_moves_ready !== s.ready ||
          am_overflow !== s.ovf || (s.chk_cnt && am_move_count !== s.cnt) ||
          (s.chk_out && (uci_out !== '0 || eval_out !== '0 || flags_out !== '0))) begin
        errors++;
        $display("FAIL status: got idle=%b busy=%b ready=%b ovf=%b cnt=%0d out=%h/%0d/%b, want idle=%b busy=%b ready=%b ovf=%b cnt=%0d(chk %b) zero_out=%b",
                 am_idle, gen_busy, am_moves_ready, am_overflow, am_move_count,
                 uci_out, eval_out, flags_out,
                 s.idle, s.busy, s.ready, s.ovf, s.cnt, s.chk_cnt, s.chk_out);
      end
    end
    if (finishing && !reported) begin
      checks++;
      if (rd_q.size() != 0 || st_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d reads and %0d status checks never observed, want 0",
                 rd_q.size(), st_q.size());
      end
      reported = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input logic idle, input logic busy, input logic ready,
                           input logic ovf, input logic chk_cnt, input logic [W-1:0] cnt,
                           input logic chk_out);
    status_t s;
    s = '{idle: idle, busy: busy, ready: ready, ovf: ovf, chk_cnt: chk_cnt, cnt: cnt,
          chk_out: chk_out};
    st_q.push_back(s);
  endtask

  task automatic wr(input logic [15:0] u, input logic signed [23:0] ev, input logic [4:0] f,
                    input logic done);
    gen_wr_en = 1'b1;
    gen_uci   = u;
    gen_eval  = ev;
    gen_flags = f;
    gen_done  = done;
    tick();
    gen_wr_en = 1'b0;
    gen_done  = 1'b0;
  endtask

  task automatic rd(input logic [W-1:0] idx, input logic [15:0] u,
                    input logic signed [23:0] ev, input logic [4:0] f);
    entry_t e;
    e = '{uci: u, eval: ev, flags: f};
    rd_q.push_back(e);
    am_move_index = idx;
    rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic pulse_start();
    gen_start = 1'b1;
    tick();
    gen_start = 1'b0;
  endtask

  task automatic pulse_clear();
    am_clear_moves = 1'b1;
    tick();
    am_clear_moves = 1'b0;
  endtask

  task automatic pulse_done();
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    expect_st(1, 0, 0, 0, 1, 0, 1);

    // 1: three moves, readback, out-of-range index reads zero
    pulse_start();
    expect_st(0, 1, 0, 0, 1, 0, 0);
    wr(16'h0C14, 24'sd25, 5'b00000, 0);
    wr(16'h0A0C, 24'sd10, 5'b00000, 0);
    wr(16'h0B12, -24'sd7, 5'b10000, 0);
    expect_st(0, 1, 0, 0, 1, 3, 0);
    pulse_done();
    expect_st(0, 0, 1, 0, 1, 3, 0);
    rd(0, 16'h0C14, 24'sd25, 5'b00000);
    rd(1, 16'h0A0C, 24'sd10, 5'b00000);
    rd(2, 16'h0B12, -24'sd7, 5'b10000);
    rd(3, 16'h0000, 24'sd0, 5'b00000);

    // 4: READY ignores gen_start/gen_wr_en, then clear back to IDLE
    gen_start = 1'b1;
    wr(16'h7777, 24'sd99, 5'b11111, 0);
    gen_start = 1'b0;
    expect_st(0, 0, 1, 0, 1, 3, 0);
    rd(0, 16'h0C14, 24'sd25, 5'b00000);
    pulse_clear();
    expect_st(0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_st(1, 0, 0, 0, 1, 0, 0);

    // 2: write in the gen_done cycle is kept
    pulse_start();
    wr(16'h1111, 24'sd1, 5'b00001, 0);
    wr(16'h2222, 24'sd2, 5'b00010, 0);
    wr(16'h3333, -24'sd3, 5'b00011, 1);
    expect_st(0, 0, 1, 0, 1, 3, 0);
    rd(2, 16'h3333, -24'sd3, 5'b00011);
    rd(0, 16'h1111, 24'sd1, 5'b00001);
    pulse_clear();
    tick();
    expect_st(1, 0, 0, 0, 1, 0, 0);

    // 3: fill past capacity (7), overflow is sticky until next gen_start
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      wr(16'h0100 + 16'(i), -24'sd1 - 24'(i), 5'(i), 0);
      if (i == 6) expect_st(0, 1, 0, 0, 1, 7, 0);
      if (i == 7) expect_st(0, 1, 0, 1, 1, 7, 0);
    end
    pulse_done();
    expect_st(0, 0, 1, 1, 1, 7, 0);
    for (int i = 0; i < 7; i++) begin
      rd(W'(i), 16'h0100 + 16'(i), -24'sd1 - 24'(i), 5'(i));
    end
    rd(7, 16'h0000, 24'sd0, 5'b00000);
    pulse_clear();
    tick();
    expect_st(1, 0, 0, 1, 1, 0, 0);
    pulse_start();
    expect_st(0, 1, 0, 0, 1, 0, 0);

    // 5: abort during FILL wins over gen_done
    wr(16'h4444, 24'sd4, 5'b00100, 0);
    wr(16'h5555, 24'sd5, 5'b00101, 0);
    gen_done = 1'b1;
    pulse_clear();
    gen_done = 1'b0;
    expect_st(0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_st(1, 0, 0, 0, 1, 0, 0);

    // 6: reset mid-FILL, then a fresh list fills from index 0
    pulse_start();
    for (int i = 0; i < 4; i++) wr(16'h0E00 + 16'(i), 24'sd50, 5'b01000, 0);
    am_move_index = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_st(1, 0, 0, 0, 1, 0, 1);
    pulse_start();
    wr(16'hAAAA, 24'sd100, 5'b01000, 0);
    wr(16'hBBBB, -24'sd100, 5'b00100, 1);
    expect_st(0, 0, 1, 0, 1, 2, 0);
    rd(0, 16'hAAAA, 24'sd100, 5'b01000);
    rd(1, 16'hBBBB, -24'sd100, 5'b00100);
    rd(2, 16'h0000, 24'sd0, 5'b00000);

    tick();
    tick();
    finishing = 1'b1;
    for (int i = 0; i < 20 && !reported; i++) tick();
    if (!reported) begin
      $display("FAIL monitor: final drain check never ran");
      $fatal(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
